// File: rtl/dr_load_sequencer.sv
// dr_load_sequencer
// Fills the 32-bit data register from byte-wide memory. One command gives a
// base address, an access size of 1, 2 or 4 bytes and a signedness flag. The
// bytes are read most-significant first, so the first register write loads
// and extends and every later write shifts the earlier bytes up. The result
// ends up right-aligned and sign- or zero-extended.

module dr_load_sequencer #(
   parameter int ADDR_W     = 16,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [1:0]        i_size,
   input  logic              i_signed,
   output logic [ADDR_W-1:0] o_memAddress,
   output logic              o_memRead,
   input  logic [7:0]        i_memData,
   input  logic              i_memReady,
   output logic              o_drE,
   output logic [1:0]        o_drFunSel,
   output logic [7:0]        o_drI,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [1:0] FUN_LOAD_SIGNED = 2'b00;
   localparam logic [1:0] FUN_LOAD_ZERO   = 2'b01;
   localparam logic [1:0] FUN_SHIFT_IN    = 2'b10;

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_nextBase;
   logic [1:0]        r_lastIdx;
   logic [1:0]        w_nextLastIdx;
   logic              r_signed;
   logic              w_nextSigned;
   logic [1:0]        r_idx;
   logic [1:0]        w_nextIdx;

   logic              w_fetch;
   logic              w_accept;
   logic [1:0]        w_offset;

   // State and command registers; reset returns to IDLE and abandons any access
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_lastIdx <= 2'd0;
         r_signed  <= 1'b0;
         r_idx     <= 2'd0;
      end else begin
         r_state   <= w_nextState;
         r_base    <= w_nextBase;
         r_lastIdx <= w_nextLastIdx;
         r_signed  <= w_nextSigned;
         r_idx     <= w_nextIdx;
      end
   end

   // Next-state logic: latch the command in IDLE, step the byte index on each
   // completed read, and leave DONE/ERR after their single pulse cycle
   always_comb begin
      w_nextState   = r_state;
      w_nextBase    = r_base;
      w_nextLastIdx = r_lastIdx;
      w_nextSigned  = r_signed;
      w_nextIdx     = r_idx;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_size == 2'b11) begin
                  w_nextState = S_ERR;
               end else begin
                  w_nextState  = S_FETCH;
                  w_nextBase   = i_address;
                  w_nextSigned = i_signed;
                  w_nextIdx    = 2'd0;
                  case (i_size)
                     2'b00:   w_nextLastIdx = 2'd0;
                     2'b01:   w_nextLastIdx = 2'd1;
                     default: w_nextLastIdx = 2'd3;
                  endcase
               end
            end
         end
         S_FETCH: begin
            if (i_memReady) begin
               if (r_idx == r_lastIdx) begin
                  w_nextState = S_DONE;
               end else begin
                  w_nextIdx = r_idx + 2'd1;
               end
            end
         end
         S_DONE:  w_nextState = S_IDLE;
         S_ERR:   w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Output decode: the byte offset walks from the most significant byte down,
   // which sits at the top address in little-endian order and at the base in
   // big-endian order; address arithmetic wraps naturally at ADDR_W bits
   always_comb begin
      w_fetch      = (r_state == S_FETCH);
      w_accept     = w_fetch && i_memReady;
      w_offset     = BIG_ENDIAN ? r_idx : (r_lastIdx - r_idx);
      o_memRead    = w_fetch;
      o_memAddress = '0;
      o_drE        = w_accept;
      o_drFunSel   = FUN_LOAD_SIGNED;
      o_drI        = i_memData;
      o_busy       = (r_state != S_IDLE);
      o_done       = (r_state == S_DONE);
      o_error      = (r_state == S_ERR);
      if (w_fetch) begin
         o_memAddress = r_base + ADDR_W'(w_offset);
      end
      if (w_accept) begin
         if (r_idx == 2'd0) begin
            o_drFunSel = r_signed ? FUN_LOAD_SIGNED : FUN_LOAD_ZERO;
         end else begin
            o_drFunSel = FUN_SHIFT_IN;
         end
      end
   end

endmodule
